// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational alu_unit.
// Round-robin grant, one transaction in flight, result held until the owner takes it.
module alu_arbiter #(
    parameter int                     DATA_WIDTH = 32,
    parameter int                     OP_WIDTH   = 6,
    parameter logic [OP_WIDTH-1:0]    OP_ALU_NOP = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic [OP_WIDTH-1:0]   i_req0_op,
    input  logic [DATA_WIDTH-1:0] i_req0_a,
    input  logic [DATA_WIDTH-1:0] i_req0_b,

    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic [OP_WIDTH-1:0]   i_req1_op,
    input  logic [DATA_WIDTH-1:0] i_req1_a,
    input  logic [DATA_WIDTH-1:0] i_req1_b,

    output logic                  o_rsp0_valid,
    input  logic                  i_rsp0_ready,
    output logic [DATA_WIDTH-1:0] o_rsp0_data,

    output logic                  o_rsp1_valid,
    input  logic                  i_rsp1_ready,
    output logic [DATA_WIDTH-1:0] o_rsp1_data,

    output logic [OP_WIDTH-1:0]   o_alu_op,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    input  logic [DATA_WIDTH-1:0] i_alu_c,

    output logic                  o_busy,
    output logic                  o_owner
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state_q, state_d;
    logic                  ptr_q;
    logic                  owner_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [DATA_WIDTH-1:0] result_q;

    logic accept;
    logic grant;
    logic rsp_fire;

    always_comb begin
        state_d  = state_q;
        // One valid wins outright; the pointer only breaks ties.
        grant    = (i_req0_valid && i_req1_valid) ? ptr_q : i_req1_valid;
        // Ready is gated by reset so nothing is acknowledged while held in reset.
        accept   = (state_q == IDLE) && (i_req0_valid || i_req1_valid) && i_rst_n;
        rsp_fire = (state_q == RESP) && (owner_q ? i_rsp1_ready : i_rsp0_ready);

        case (state_q)
            IDLE:    if (accept)   state_d = EXEC;
            EXEC:                  state_d = RESP;
            RESP:    if (rsp_fire) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            op_q     <= OP_ALU_NOP;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= grant;
                op_q    <= grant ? i_req1_op : i_req0_op;
                a_q     <= grant ? i_req1_a  : i_req0_a;
                b_q     <= grant ? i_req1_b  : i_req0_b;
            end
            if (state_q == EXEC)
                result_q <= i_alu_c;
            if (rsp_fire)
                ptr_q <= ~owner_q;
        end
    end

    // The shared ALU sees a quiet NOP with zero operands except during EXEC.
    assign o_alu_op = (state_q == EXEC) ? op_q : OP_ALU_NOP;
    assign o_alu_a  = (state_q == EXEC) ? a_q  : '0;
    assign o_alu_b  = (state_q == EXEC) ? b_q  : '0;

    assign o_req0_ready = accept && !grant;
    assign o_req1_ready = accept &&  grant;

    assign o_rsp0_valid = (state_q == RESP) && !owner_q;
    assign o_rsp1_valid = (state_q == RESP) &&  owner_q;
    assign o_rsp0_data  = result_q;
    assign o_rsp1_data  = result_q;

    assign o_busy  = (state_q != IDLE);
    assign o_owner = owner_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural alu_unit plus scenario tasks and a
// randomized run checked against a transaction-level arbitration model.
module tb_alu_arbiter;

    localparam logic [5:0] OP_NOP = 6'd0;
    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;
    localparam logic [5:0] OP_AND = 6'd3;
    localparam logic [5:0] OP_OR  = 6'd4;
    localparam logic [5:0] OP_XOR = 6'd5;
    localparam logic [5:0] OP_SRA = 6'd6;

    logic        clk, rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [5:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic [5:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_c;
    logic        busy, owner;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(6), .OP_ALU_NOP(OP_NOP)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
        .i_req0_op(req0_op), .i_req0_a(req0_a), .i_req0_b(req0_b),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
        .i_req1_op(req1_op), .i_req1_a(req1_a), .i_req1_b(req1_b),
        .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready), .o_rsp0_data(rsp0_data),
        .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready), .o_rsp1_data(rsp1_data),
        .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b), .i_alu_c(alu_c),
        .o_busy(busy), .o_owner(owner)
    );

    function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [5:0] rand_op();
        case ($urandom_range(0, 5))
            0: return OP_ADD;
            1: return OP_SUB;
            2: return OP_AND;
            3: return OP_OR;
            4: return OP_XOR;
            default: return OP_SRA;
        endcase
    endfunction

    assign alu_c = alu_ref(alu_op, alu_a, alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_accept(output logic who, output bit ok);
        ok = 1'b0; who = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                who = req1_ready; ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_resp(output logic who, output logic [31:0] data, output bit ok);
        ok = 1'b0; who = 1'b0; data = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) begin
                who = rsp1_valid; data = rsp1_valid ? rsp1_data : rsp0_data; ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = OP_ADD; req0_a = 32'd1; req0_b = 32'd2;
        req1_op = OP_SUB; req1_a = 32'd3; req1_b = 32'd4;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, owner} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=000000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, owner});
        end
        checks++;
        if (alu_op !== OP_NOP || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            errors++; $display("FAIL reset_alu got=%h/%h/%h exp=00/0/0", alu_op, alu_a, alu_b);
        end
        checks++;
        if (rsp0_data !== 32'd0 || rsp1_data !== 32'd0) begin
            errors++; $display("FAIL reset_data got=%h/%h exp=0", rsp0_data, rsp1_data);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (alu_op !== OP_NOP || alu_a !== 32'd0 || alu_b !== 32'd0 || busy !== 1'b0 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                errors++; $display("FAIL idle_quiet cyc=%0d got op=%h a=%h b=%h busy=%b exp op=00 a=0 b=0 busy=0", i, alu_op, alu_a, alu_b, busy);
            end
        end
    endtask

    task automatic test_basic();
        @(posedge clk);
        #1 req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd5; req0_b = 32'd3; rsp0_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL basic_accept got=%b%b exp=10", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_op !== OP_ADD || alu_a !== 32'd5 || alu_b !== 32'd3 || busy !== 1'b1 || req0_ready !== 1'b0 || rsp0_valid !== 1'b0) begin
            errors++; $display("FAIL basic_exec got op=%h a=%h b=%h busy=%b exp op=%h a=5 b=3 busy=1", alu_op, alu_a, alu_b, busy, OP_ADD);
        end
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h8 || rsp1_valid !== 1'b0 || owner !== 1'b0 || alu_op !== OP_NOP) begin
            errors++; $display("FAIL basic_resp got v=%b d=%h own=%b op=%h exp v=1 d=00000008 own=0 op=00", rsp0_valid, rsp0_data, owner, alu_op);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            errors++; $display("FAIL basic_done got busy=%b v=%b exp 0 0", busy, rsp0_valid);
        end
    endtask

    task automatic test_alternate();
        logic [31:0] expv [2];
        logic [31:0] exp_d, data;
        logic        who, rw;
        bit          ok;
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_op = OP_SUB; req0_a = 32'hA; req0_b = 32'd3;
        req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 32'h0F0F0F0F; req1_b = 32'h00FF00FF;
        expv[0] = alu_ref(req0_op, req0_a, req0_b);
        expv[1] = alu_ref(req1_op, req1_a, req1_b);
        for (int k = 0; k < 4; k++) begin
            wait_accept(who, ok);
            checks++;
            if (!ok || who !== k[0]) begin
                errors++; $display("FAIL alt_grant%0d got ok=%b who=%b exp ok=1 who=%b", k, ok, who, k[0]);
            end
            exp_d = expv[who];
            @(posedge clk);
            #1;
            if (who) begin
                req1_op = rand_op(); req1_a = $urandom; req1_b = $urandom;
                expv[1] = alu_ref(req1_op, req1_a, req1_b);
            end else begin
                req0_op = rand_op(); req0_a = $urandom; req0_b = $urandom;
                expv[0] = alu_ref(req0_op, req0_a, req0_b);
            end
            wait_resp(rw, data, ok);
            checks++;
            if (!ok || rw !== who || data !== exp_d || owner !== who) begin
                errors++; $display("FAIL alt_resp%0d got ok=%b who=%b own=%b d=%h exp who=%b d=%h", k, ok, rw, owner, data, who, exp_d);
            end
            if (k < 2) begin
                checks++;
                if (data !== (k == 0 ? 32'h7 : 32'h0FF00FF0)) begin
                    errors++; $display("FAIL alt_const%0d got=%h exp=%h", k, data, (k == 0 ? 32'h7 : 32'h0FF00FF0));
                end
            end
        end
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic        who;
        logic [31:0] data, exp0;
        bit          ok;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        @(posedge clk);
        #1 req1_valid = 1'b1; req1_op = OP_SRA; req1_a = 32'hFFFFFFF0; req1_b = 32'd2;
        wait_accept(who, ok);
        checks++;
        if (!ok || who !== 1'b1) begin
            errors++; $display("FAIL stall_grant got ok=%b who=%b exp 1 1", ok, who);
        end
        @(posedge clk);
        #1 req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = $urandom; req0_b = $urandom;
        exp0 = alu_ref(req0_op, req0_a, req0_b);
        wait_resp(who, data, ok);
        checks++;
        if (!ok || who !== 1'b1 || data !== 32'hFFFFFFFC) begin
            errors++; $display("FAIL stall_resp got ok=%b who=%b d=%h exp who=1 d=fffffffc", ok, who, data);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp1_valid !== 1'b1 || rsp1_data !== 32'hFFFFFFFC || req0_ready !== 1'b0 || rsp0_valid !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d got v=%b d=%h rdy0=%b exp v=1 d=fffffffc rdy0=0", i, rsp1_valid, rsp1_data, req0_ready);
            end
        end
        @(posedge clk);
        #1 rsp1_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp1_valid !== 1'b1 || req0_ready !== 1'b0) begin
            errors++; $display("FAIL stall_hs got v=%b rdy0=%b exp v=1 rdy0=0", rsp1_valid, req0_ready);
        end
        @(negedge clk);
        checks++;
        if (rsp1_valid !== 1'b0 || req0_ready !== 1'b1) begin
            errors++; $display("FAIL stall_next got v=%b rdy0=%b exp v=0 rdy0=1", rsp1_valid, req0_ready);
        end
        @(posedge clk);
        #1 req0_valid = 1'b0; rsp0_ready = 1'b1;
        wait_resp(who, data, ok);
        checks++;
        if (!ok || who !== 1'b0 || data !== exp0) begin
            errors++; $display("FAIL stall_req0 got ok=%b who=%b d=%h exp who=0 d=%h", ok, who, data, exp0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_exec();
        logic        who;
        logic [31:0] data, exp0;
        bit          ok;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        // pointer now favours req1; the mid-flight reset must return it to req0
        @(posedge clk);
        #1 req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 32'd9; req1_b = 32'd9;
        wait_accept(who, ok);
        @(posedge clk);
        #1 req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || alu_op !== OP_ADD) begin
            errors++; $display("FAIL rexec_pre got busy=%b op=%h exp 1 %h", busy, alu_op, OP_ADD);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || alu_op !== OP_NOP || owner !== 1'b0) begin
            errors++; $display("FAIL rexec_abort got busy=%b v=%b%b op=%h own=%b exp 0 00 00 0", busy, rsp0_valid, rsp1_valid, alu_op, owner);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = OP_OR; req0_a = $urandom; req0_b = $urandom;
        req1_valid = 1'b1;
        exp0 = alu_ref(req0_op, req0_a, req0_b);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++; $display("FAIL rexec_grant got rdy=%b%b exp=10", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_resp(who, data, ok);
        checks++;
        if (!ok || who !== 1'b0 || data !== exp0) begin
            errors++; $display("FAIL rexec_resp got ok=%b who=%b d=%h exp who=0 d=%h", ok, who, data, exp0);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        bit          pend [2];
        logic [5:0]  p_op [2];
        logic [31:0] p_a [2], p_b [2];
        bit          mbusy, mown, pref, er0, er1, ev0, ev1, rr;
        int          cyc, resp_at;
        logic [31:0] mexp;
        int          served;
        do_reset();
        pend[0] = 0; pend[1] = 0; mbusy = 0; mown = 0; pref = 0;
        cyc = 0; resp_at = 0; mexp = '0; served = 0;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #1;
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1; p_op[r] = rand_op(); p_a[r] = $urandom; p_b[r] = $urandom;
                end
            end
            req0_valid = pend[0]; req0_op = p_op[0]; req0_a = p_a[0]; req0_b = p_b[0];
            req1_valid = pend[1]; req1_op = p_op[1]; req1_a = p_a[1]; req1_b = p_b[1];
            rsp0_ready = ($urandom_range(0, 9) < 6);
            rsp1_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            er0 = !mbusy && pend[0] && (!pend[1] || pref == 0);
            er1 = !mbusy && pend[1] && (!pend[0] || pref == 1);
            ev0 = mbusy && cyc >= resp_at && mown == 0;
            ev1 = mbusy && cyc >= resp_at && mown == 1;
            checks++;
            if (req0_ready !== er0 || req1_ready !== er1) begin
                errors++; $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b%b", cyc, req0_ready, req1_ready, er0, er1);
            end
            checks++;
            if (rsp0_valid !== ev0 || rsp1_valid !== ev1 || busy !== mbusy) begin
                errors++; $display("FAIL rnd_state cyc=%0d got v=%b%b busy=%b exp v=%b%b busy=%b", cyc, rsp0_valid, rsp1_valid, busy, ev0, ev1, mbusy);
            end
            if (ev0 || ev1) begin
                checks++;
                if ((ev1 ? rsp1_data : rsp0_data) !== mexp || owner !== mown) begin
                    errors++; $display("FAIL rnd_data cyc=%0d got d=%h own=%b exp d=%h own=%b", cyc, (ev1 ? rsp1_data : rsp0_data), owner, mexp, mown);
                end
            end
            if (er0 || er1) begin
                mown = er1; mbusy = 1; resp_at = cyc + 2;
                mexp = alu_ref(p_op[mown], p_a[mown], p_b[mown]);
                pend[mown] = 0;
            end else if (ev0 || ev1) begin
                rr = mown ? rsp1_ready : rsp0_ready;
                if (rr) begin
                    mbusy = 0; pref = !mown; served++;
                end
            end
            cyc++;
        end
        checks++;
        if (served < 20) begin
            errors++; $display("FAIL rnd_progress got=%0d exp>=20", served);
        end
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic();
        test_alternate();
        test_stall();
        test_reset_exec();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
